// File: rtl/fir_sweep_pkg.sv
// Shared types and elaboration helpers for the FIR frequency-sweep sequencer.
// Contents: sweep state encoding, counter-width helper, parameter legality check.
package fir_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_SETTLE  = 3'd3,
        S_MEASURE = 3'd4,
        S_REPORT  = 3'd5
    } state_e;

    // Width of a counter that must hold 0..max_val (never narrower than 1 bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // True when the sequencer parameters describe a runnable sweep.
    function automatic bit params_ok(input int unsigned lanes,
                                     input int unsigned num_sections,
                                     input int unsigned settle_cycles,
                                     input int unsigned window_cycles);
        return (lanes >= 1) && (num_sections >= 2) &&
               (settle_cycles >= 1) && (window_cycles >= 1);
    endfunction

endpackage

// File: rtl/signed_max_tree.sv
// Combinational signed maximum over LANES values of OUT_W bits each.
// Ports: i_vals - packed lane values (two's complement); o_max_c - largest lane value.
module signed_max_tree
    import fir_sweep_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned OUT_W = 40
) (
    input  logic [LANES-1:0][OUT_W-1:0] i_vals,
    output logic signed [OUT_W-1:0]     o_max_c
);

    // Linear compare chain; lane counts in use are small.
    logic signed [OUT_W-1:0] w_chain [LANES];

    assign w_chain[0] = $signed(i_vals[0]);

    for (genvar g = 1; g < LANES; g++) begin : g_stage
        assign w_chain[g] = ($signed(i_vals[g]) > w_chain[g-1]) ? $signed(i_vals[g])
                                                                 : w_chain[g-1];
    end

    assign o_max_c = w_chain[LANES-1];

endmodule

// File: rtl/fir_sweep_ctrl.sv
// Frequency-response sweep sequencer for the L-parallel FIR datapath.
// Per section: fetch stimulus from LUT, drive it on every lane, settle, track the
// signed peak over all lane outputs for WINDOW_CYCLES+1 cycles, then report it.
// Ports: clk/rst_n clock and async active-low reset; start/abort control;
//        lut_addr/lut_data stimulus LUT; fir_inp/fir_outp FIR lanes;
//        res_valid/res_ready/res_section/res_peak result channel; busy/done status.
module fir_sweep_ctrl
    import fir_sweep_pkg::*;
#(
    parameter int unsigned LANES         = 2,
    parameter int unsigned IN_W          = 16,
    parameter int unsigned OUT_W         = 40,
    parameter int unsigned NUM_SECTIONS  = 27,
    parameter int unsigned SETTLE_CYCLES = 340,
    parameter int unsigned WINDOW_CYCLES = 2000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    output logic [$clog2(NUM_SECTIONS)-1:0]     lut_addr,
    input  logic signed [IN_W-1:0]              lut_data,
    output logic [LANES-1:0][IN_W-1:0]          fir_inp,
    input  logic [LANES-1:0][OUT_W-1:0]         fir_outp,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [$clog2(NUM_SECTIONS)-1:0]     res_section,
    output logic signed [OUT_W-1:0]             res_peak,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned SEC_W   = $clog2(NUM_SECTIONS);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES
                                                                      : WINDOW_CYCLES;
    localparam int unsigned CNT_W   = cnt_w(CNT_MAX);

    if (!params_ok(LANES, NUM_SECTIONS, SETTLE_CYCLES, WINDOW_CYCLES)) begin : g_param_check
        $error("fir_sweep_ctrl: illegal parameter set");
    end

    state_e                     r_state, w_state_nxt;
    logic [SEC_W-1:0]           r_section, w_section_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic signed [OUT_W-1:0]    r_peak, w_peak_nxt;
    logic [LANES-1:0][IN_W-1:0] r_fir, w_fir_nxt;
    logic [SEC_W-1:0]           r_lut_addr, w_lut_addr_nxt;
    logic                       r_res_valid, w_res_valid_nxt;
    logic [SEC_W-1:0]           r_res_section, w_res_section_nxt;
    logic signed [OUT_W-1:0]    r_res_peak, w_res_peak_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_done, w_done_nxt;

    logic signed [OUT_W-1:0]    w_lane_max;
    logic signed [OUT_W-1:0]    w_peak_max;
    logic signed [OUT_W-1:0]    w_peak_upd;
    logic [1:0][OUT_W-1:0]      w_peak_pair;

    // Max across lanes this cycle, then folded into the running peak.
    signed_max_tree #(.LANES(LANES), .OUT_W(OUT_W)) u_lane_max (
        .i_vals  (fir_outp),
        .o_max_c (w_lane_max)
    );

    assign w_peak_pair = {r_peak, w_lane_max};

    signed_max_tree #(.LANES(2), .OUT_W(OUT_W)) u_peak_max (
        .i_vals  (w_peak_pair),
        .o_max_c (w_peak_max)
    );

    // First window cycle seeds the peak so a stale value never leaks across sections.
    assign w_peak_upd = (r_cnt == '0) ? w_lane_max : w_peak_max;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_section_nxt     = r_section;
        w_cnt_nxt         = r_cnt;
        w_peak_nxt        = r_peak;
        w_fir_nxt         = r_fir;
        w_lut_addr_nxt    = r_lut_addr;
        w_res_section_nxt = r_res_section;
        w_res_peak_nxt    = r_res_peak;
        w_done_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_FETCH;
                    w_section_nxt  = SEC_W'(1);
                    w_lut_addr_nxt = SEC_W'(1);
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_fir_nxt   = {LANES{lut_data}};
                w_cnt_nxt   = '0;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_MEASURE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_MEASURE: begin
                w_peak_nxt = w_peak_upd;
                if (r_cnt == CNT_W'(WINDOW_CYCLES)) begin
                    w_cnt_nxt         = '0;
                    w_res_section_nxt = r_section;
                    w_res_peak_nxt    = w_peak_upd;
                    w_state_nxt       = S_REPORT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    if (r_section == SEC_W'(NUM_SECTIONS - 1)) begin
                        w_done_nxt    = 1'b1;
                        w_section_nxt = SEC_W'(1);
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_section_nxt  = r_section + SEC_W'(1);
                        w_lut_addr_nxt = r_section + SEC_W'(1);
                        w_state_nxt    = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE, including a same-cycle handshake.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_section_nxt  = SEC_W'(1);
            w_cnt_nxt      = '0;
            w_fir_nxt      = '0;
            w_lut_addr_nxt = '0;
            w_done_nxt     = 1'b0;
        end

        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_res_valid_nxt = (w_state_nxt == S_REPORT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_section     <= SEC_W'(1);
            r_cnt         <= '0;
            r_peak        <= '0;
            r_fir         <= '0;
            r_lut_addr    <= '0;
            r_res_valid   <= 1'b0;
            r_res_section <= '0;
            r_res_peak    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_section     <= w_section_nxt;
            r_cnt         <= w_cnt_nxt;
            r_peak        <= w_peak_nxt;
            r_fir         <= w_fir_nxt;
            r_lut_addr    <= w_lut_addr_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_res_section <= w_res_section_nxt;
            r_res_peak    <= w_res_peak_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign lut_addr    = r_lut_addr;
    assign fir_inp     = r_fir;
    assign res_valid   = r_res_valid;
    assign res_section = r_res_section;
    assign res_peak    = r_res_peak;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_fir_sweep_ctrl.sv
// Directed self-checking bench for fir_sweep_ctrl (LANES=2, 4 sections, settle 3, window 5).
module tb_fir_sweep_ctrl;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [1:0]        lut_addr;
    logic signed [15:0] lut_data;
    logic [1:0][15:0]  fir_inp;
    logic [1:0][39:0]  fir_outp;
    logic [1:0][39:0]  tb_outp;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_section;
    logic signed [39:0] res_peak;
    logic              busy;
    logic              done;

    logic              mode;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                t0, t1, t2, t3;
    logic              saw_v, saw_d, saw_b;

    fir_sweep_ctrl #(
        .LANES(2), .IN_W(16), .OUT_W(40),
        .NUM_SECTIONS(4), .SETTLE_CYCLES(3), .WINDOW_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .fir_inp(fir_inp), .fir_outp(fir_outp),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_section(res_section), .res_peak(res_peak),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus LUT: addr*100, one cycle latency.
    always @(posedge clk) lut_data <= 16'(32'(lut_addr) * 32'd100);

    // FIR model: pass-through of the lane input, or bench-driven lane outputs.
    always_comb begin
        fir_outp[0] = mode ? tb_outp[0] : 40'($signed(fir_inp[0]));
        fir_outp[1] = mode ? tb_outp[1] : 40'($signed(fir_inp[1]));
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("res_valid_seen", longint'(res_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; res_ready = 1'b1;
        mode = 1'b0; tb_outp = '0;

        // 1. reset with start held high
        tick(); tick();
        check("rst_busy", longint'(busy), 0);
        check("rst_lut_addr", longint'(lut_addr), 0);
        check("rst_fir_inp", longint'(fir_inp), 0);
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_res_section", longint'(res_section), 0);
        check("rst_res_peak", longint'(res_peak), 0);
        check("rst_done", longint'(done), 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("idle_busy", longint'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        check("start_busy", longint'(busy), 1);
        check("start_lut_addr", longint'(lut_addr), 1);

        // 2. full sweep with pass-through FIR
        wait_valid(40);
        t1 = cyc;
        check("s1_latency", longint'(t1 - t0), 11);
        check("s1_section", longint'(res_section), 1);
        check("s1_peak", longint'(res_peak), 100);
        check("s1_fir_lane1", longint'($signed(fir_inp[1])), 100);
        tick();
        wait_valid(40);
        t2 = cyc;
        check("s2_spacing", longint'(t2 - t1), 12);
        check("s2_section", longint'(res_section), 2);
        check("s2_peak", longint'(res_peak), 200);
        tick();
        wait_valid(40);
        t3 = cyc;
        check("s3_spacing", longint'(t3 - t2), 12);
        check("s3_section", longint'(res_section), 3);
        check("s3_peak", longint'(res_peak), 300);
        tick();
        check("sweep_done", longint'(done), 1);
        check("sweep_idle", longint'(busy), 0);
        check("sweep_valid_low", longint'(res_valid), 0);
        tick();
        check("done_one_cycle", longint'(done), 0);

        // 3. signed peak across lanes
        mode = 1'b1;
        tb_outp[0] = 40'(-9); tb_outp[1] = 40'(-7);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        tb_outp[0] = 40'(-2);
        tick();
        tb_outp[0] = 40'(-9);
        wait_valid(20);
        check("neg_peak_section", longint'(res_section), 1);
        check("neg_peak", longint'(res_peak), -2);
        tick();
        for (int i = 0; i < 5; i++) tick();
        tb_outp[1] = 40'(5);
        tick();
        tb_outp[1] = 40'(-7);
        wait_valid(20);
        check("init_peak_section", longint'(res_section), 2);
        check("init_peak", longint'(res_peak), 5);
        tick();
        wait_valid(20);
        check("fresh_peak", longint'(res_peak), -7);
        tick();
        check("neg_sweep_done", longint'(done), 1);
        tick();

        // 4. backpressure
        mode = 1'b0;
        res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", longint'(res_valid), 1);
            check("bp_section", longint'(res_section), 1);
            check("bp_peak", longint'(res_peak), 100);
            check("bp_fir_inp", longint'($signed(fir_inp[0])), 100);
            check("bp_lut_addr", longint'(lut_addr), 1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", longint'(res_valid), 0);
        check("bp_release_lut_addr", longint'(lut_addr), 2);
        check("bp_release_busy", longint'(busy), 1);

        // 5. abort in MEASURE of section 2
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_fir_inp", longint'(fir_inp), 0);
        check("abort_valid", longint'(res_valid), 0);
        check("abort_done", longint'(done), 0);
        saw_v = 1'b0; saw_d = 1'b0; saw_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_v |= res_valid; saw_d |= done; saw_b |= busy;
        end
        check("abort_no_valid", longint'(saw_v), 0);
        check("abort_no_done", longint'(saw_d), 0);
        check("abort_stays_idle", longint'(saw_b), 0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("rerun_busy", longint'(busy), 1);
        check("rerun_lut_addr", longint'(lut_addr), 1);
        wait_valid(20);
        check("rerun_section", longint'(res_section), 1);
        check("rerun_peak", longint'(res_peak), 100);

        // 6. async reset mid-SETTLE of section 2
        tick();
        tick(); tick(); tick();
        check("pre_reset_fir_inp", longint'($signed(fir_inp[0])), 200);
        check("pre_reset_busy", longint'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", longint'(busy), 0);
        check("arst_fir_inp", longint'(fir_inp), 0);
        check("arst_lut_addr", longint'(lut_addr), 0);
        check("arst_res_section", longint'(res_section), 0);
        check("arst_res_peak", longint'(res_peak), 0);
        check("arst_res_valid", longint'(res_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_b = 1'b0; saw_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_b |= busy; saw_v |= res_valid;
        end
        check("post_reset_idle", longint'(saw_b), 0);
        check("post_reset_no_valid", longint'(saw_v), 0);
        check("post_reset_lut_addr", longint'(lut_addr), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
